// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle; signs are fixed at commit.
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam logic [2:0] OpMthi = 3'b100;
  localparam logic [2:0] OpMtlo = 3'b101;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier}. Divide: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // md_op[0] selects the unsigned variant, so sign flags only matter when it is clear.
  always_comb begin
    a_neg = ~md_op[0] & A[WIDTH-1];
    b_neg = ~md_op[0] & B[WIDTH-1];
    a_abs = a_neg ? (~A + 1'b1) : A;
    b_abs = b_neg ? (~B + 1'b1) : B;
  end

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh  = {rem_q, acc_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opnd_q};
    // On no-borrow the difference is below the divisor, so it always fits in WIDTH bits.
    div_sub = WIDTH'(div_sh - {1'b0, opnd_q});
  end

  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          if (!md_op[2]) begin
            state_d  = StCalc;
            cnt_d    = CW'(WIDTH - 1);
            is_div_d = md_op[1];
            neg_d    = a_neg ^ b_neg;
            rem_d    = '0;
            if (md_op[1]) begin
              acc_d     = {{WIDTH{1'b0}}, a_abs};
              opnd_d    = b_abs;
              neg_rem_d = a_neg;
              dz_d      = (B == '0);
            end else begin
              acc_d     = {{WIDTH{1'b0}}, b_abs};
              opnd_d    = a_abs;
              neg_rem_d = 1'b0;
              dz_d      = 1'b0;
            end
          end else if (md_op == OpMthi) begin
            hi_d = A;
          end else if (md_op == OpMtlo) begin
            lo_d = A;
          end
        end
      end

      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          if (is_div_q) begin
            acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
            rem_d = div_ge ? div_sub : div_sh[WIDTH-1:0];
          end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) begin
            state_d = StFix;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      StFix: begin
        state_d = StIdle;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide by zero: quotient saturates to all ones and the remainder is the dividend.
            lo_d = dz_q ? '1 : quo_fix;
            hi_d = rem_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: expected {hi,lo} pushed at issue, popped on each done pulse.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rstn;
  logic         start;
  logic [2:0]   md_op;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0]  sb_q[$];
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .md_op (md_op),
    .A     (A),
    .B     (B),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like MIPS.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (op)
      3'd0: r = 64'(sa * sb);
      3'd1: r = 64'(ua * ub);
      3'd2: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else         r = {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: begin
        if (b == '0) r = {a, 32'hFFFF_FFFF};
        else         r = {32'(ua % ub), 32'(ua / ub)};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit expect_result);
    logic [63:0] r;
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    if (expect_result) begin
      if (!op[2]) begin
        r = model(op, a, b);
        sb_q.push_back(r);
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end else if (op == 3'd4) begin
        exp_hi = a;
      end else if (op == 3'd5) begin
        exp_lo = a;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Call straight after issue; counts busy cycles from the start edge.
  task automatic wait_done(input bit chk_busy);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required drop", n);
    end
    if (chk_busy) check("busy_cycles", W'(n), W'(W + 1));
    check("done_at_busy_drop", W'(done), W'(1));
    @(posedge clk);
    #1;
    check("done_one_cycle", W'(done), W'(0));
  endtask

  always @(negedge clk) begin
    if (rstn && done) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 with no op outstanding, required no pulse");
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("sb_hi", hi, e[63:32]);
        check("sb_lo", lo, e[31:0]);
      end
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return W'($urandom_range(0, 20));
      5: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rstn  = 1'b0;
    start = 1'b0;
    md_op = '0;
    A     = '0;
    B     = '0;
    flush = 1'b0;
    #12;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_hi", hi, '0);
    check("rst_lo", lo, '0);
    @(negedge clk);
    rstn = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b1);
    issue(3'd0, -32'sd3, 32'd7, 1'b1);
    wait_done(1'b1);
    issue(3'd2, -32'sd7, 32'd2, 1'b1);
    wait_done(1'b1);
    issue(3'd3, 32'd100, 32'd0, 1'b1);
    wait_done(1'b1);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b1);
    issue(3'd2, -32'sd100, 32'd0, 1'b1);
    wait_done(1'b1);

    issue(3'd4, 32'h1234, 32'd0, 1'b1);
    check("mthi_no_busy", W'(busy), W'(0));
    issue(3'd5, 32'h5678, 32'd0, 1'b1);
    check("mtlo_no_busy", W'(busy), W'(0));
    check("mthi_hi", hi, 32'h1234);
    check("mtlo_lo", lo, 32'h5678);
    issue(3'd6, 32'hAAAA, 32'hBBBB, 1'b1);
    check("noop_hi", hi, exp_hi);
    check("noop_lo", lo, exp_lo);

    // A start while busy must be dropped, including an MTHI.
    issue(3'd0, 32'd12345, -32'sd9, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    md_op = 3'd4;
    A     = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0);
    check("busy_start_hi", hi, exp_hi);

    issue(3'd3, 32'd9, 32'd2, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi_kept", hi, exp_hi);
    check("flush_lo_kept", lo, exp_lo);

    @(negedge clk);
    flush = 1'b1;
    start = 1'b1;
    md_op = 3'd4;
    A     = 32'hBEEF;
    @(posedge clk);
    #1;
    flush = 1'b0;
    start = 1'b0;
    check("flush_beats_mthi", hi, exp_hi);

    issue(3'd1, 32'd6, 32'd7, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_busy", W'(busy), W'(0));
    check("arst_done", W'(done), W'(0));
    check("arst_hi", hi, '0);
    check("arst_lo", lo, '0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    rstn = 1'b1;
    issue(3'd1, 32'd6, 32'd7, 1'b1);
    wait_done(1'b1);
    check("post_rst_lo", lo, 32'd42);
    check("post_rst_hi", hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = pick();
      b  = pick();
      issue(op, a, b, 1'b1);
      if (!op[2]) begin
        wait_done(1'b1);
      end else begin
        check("rand_mt_hi", hi, exp_hi);
        check("rand_mt_lo", lo, exp_lo);
      end
    end

    repeat (5) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drained: got %0d outstanding results, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
